vga_line_fetch: RTL and testbench

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_line_ram.sv | 25 ++
 rtl/vga_line_fetch.sv | 132 +++++++++++++
 tb/tb_vga_line_fetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and address helper for the VGA line fetcher.
package vga_pkg;

  localparam int H_VALID = 640;
  localparam int V_VALID = 480;
  localparam int PIX_W   = 10;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;

  localparam logic [PIX_W-1:0] PIX_NONE = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA
  } fetch_state_t;

  // Start word address of a line; wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [PIX_W-1:0]  line,
                                                  input int unsigned       h);
    return base + ADDR_W'(line) * ADDR_W'(h);
  endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Simple dual-port line buffer: one write port, one synchronous read port.
module vga_line_ram #(
  parameter int DEPTH  = 1280,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Double-buffered scanline fetcher: bursts one line from memory into a bank
// while the display reads the other bank.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'h00000
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        rd_req,
  output logic [19:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        fetch_busy,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  localparam int RAM_DEPTH = 2 * H_VALID;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  localparam logic [PIX_W-1:0]  LAST_X    = PIX_W'(H_VALID - 1);
  localparam logic [PIX_W-1:0]  LAST_Y    = PIX_W'(V_VALID - 1);
  localparam logic [RAM_AW-1:0] BANK1_OFS = RAM_AW'(H_VALID);

  fetch_state_t state, state_next;

  logic [PIX_W-1:0] wcnt, wcnt_next;
  logic [PIX_W-1:0] line, line_next;
  logic [PIX_W-1:0] target, start_line;
  logic             boot;
  logic             rd_en_q;
  logic             line_end, final_word;
  logic             trigger, overrun;

  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic [15:0]       ram_q;

  assign line_end   = (pix_x == LAST_X) && (pix_y != PIX_NONE);
  assign target     = (pix_y == LAST_Y) ? '0 : pix_y + PIX_W'(1);
  assign final_word = (state == ST_DATA) && rd_valid && (wcnt == LAST_X);

  // A line_end coinciding with the last word chains straight into the next
  // fetch; any other line_end while busy is an underrun and is dropped.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    line_next  = line;
    start_line = target;
    trigger    = 1'b0;
    overrun    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (boot || line_end) begin
          trigger    = 1'b1;
          start_line = boot ? '0 : target;
        end
      end
      ST_REQ: begin
        if (line_end) overrun = 1'b1;
        if (rd_ack) begin
          state_next = ST_DATA;
          wcnt_next  = '0;
        end
      end
      ST_DATA: begin
        if (rd_valid) wcnt_next = wcnt + PIX_W'(1);
        if (final_word) begin
          state_next = ST_IDLE;
          if (line_end) trigger = 1'b1;
        end else if (line_end) begin
          overrun = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (trigger) begin
      state_next = ST_REQ;
      line_next  = start_line;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wcnt         <= '0;
      line         <= '0;
      rd_addr      <= '0;
      boot         <= 1'b1;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      rd_en_q      <= 1'b0;
    end else begin
      state    <= state_next;
      wcnt     <= wcnt_next;
      line     <= line_next;
      boot     <= 1'b0;
      underrun <= overrun;
      rd_en_q  <= (pix_x != PIX_NONE) && (pix_y != PIX_NONE);
      if (trigger) rd_addr <= line_addr(BASE_ADDR, start_line, H_VALID);
      if (overrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  assign rd_req     = (state == ST_REQ);
  assign fetch_busy = (state != ST_IDLE);

  assign ram_we    = (state == ST_DATA) && rd_valid;
  assign ram_waddr = (line[0]  ? BANK1_OFS : '0) + RAM_AW'(wcnt);
  assign ram_raddr = (pix_y[0] ? BANK1_OFS : '0) + RAM_AW'(pix_x);

  vga_line_ram #(
    .DEPTH  (RAM_DEPTH),
    .DATA_W (16),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (vga_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (rd_data),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  assign pix_data = rd_en_q ? ram_q : '0;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Self-checking bench for vga_line_fetch: memory responder, bank model, readback tables.
`timescale 1ns/1ps
module tb_vga_line_fetch;

  localparam int HV = 640;
  localparam int VV = 480;
  localparam logic [9:0] NONE = 10'h3FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_data;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        rd_ack, rd_valid;
  logic [15:0] rd_data;
  logic        fetch_busy, underrun;
  logic [7:0]  underrun_cnt;

  int checks = 0;
  int passed = 0;
  int exp_cnt = 0;
  int unsigned bank [2][HV];

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  vga_line_fetch #(.BASE_ADDR(20'h00000)) dut (
    .vga_clk      (clk),
    .rst_n        (rst_n),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .fetch_busy   (fetch_busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int line_addr(input int l);
    return (l * HV) % (1 << 20);
  endfunction

  function automatic int sat_inc(input int c, input int n);
    return (c + n > 255) ? 255 : c + n;
  endfunction

  // Acts as the memory: waits for a request, acks after ack_delay cycles and
  // streams nwords words with random gaps. mid_y / end_y inject line_end at
  // word 100 / on the final word (negative = none).
  task automatic serve(input int line, input int unsigned pat, input int ack_delay,
                       input int nwords, input int mid_y, input int end_y);
    int n = 0;
    while (!rd_req && n < 50) begin tick(); n++; end
    check("rd_req_raised", rd_req, 1);
    if (!rd_req) return;
    check("rd_addr", rd_addr, line_addr(line));
    repeat (ack_delay) tick();
    check("rd_req_held", rd_req, 1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("busy_in_data", fetch_busy, 1);
    for (int i = 0; i < nwords; i++) begin
      pix_x = NONE; pix_y = NONE;
      if ($urandom_range(0, 3) == 0) begin rd_valid = 1'b0; tick(); end
      rd_valid = 1'b1;
      rd_data  = 16'((i ^ pat) & 16'hFFFF);
      bank[line % 2][i] = (i ^ pat) & 16'hFFFF;
      if (i == 100 && mid_y >= 0) begin pix_x = 10'(HV - 1); pix_y = 10'(mid_y); end
      if (i == HV - 1 && end_y >= 0) begin pix_x = 10'(HV - 1); pix_y = 10'(end_y); end
      tick();
      if (i == 100 && mid_y >= 0) begin
        exp_cnt = sat_inc(exp_cnt, 1);
        check("underrun_mid_data", underrun, 1);
      end
    end
    rd_valid = 1'b0; pix_x = NONE; pix_y = NONE;
    if (nwords == HV) begin
      if (end_y < 0) check("busy_after_last", fetch_busy, 0);
      check("no_underrun_at_end", underrun, 0);
      check("underrun_cnt_after_burst", underrun_cnt, exp_cnt);
    end
  endtask

  task automatic run_table();
    vec_t tbl [16];
    for (int i = 0; i < 16; i++) begin
      tbl[i].x = 10'($urandom_range(0, HV - 2));
      tbl[i].y = 10'($urandom_range(0, VV - 1));
      if (i % 7 == 3) tbl[i].x = NONE;
      if (i % 7 == 5) tbl[i].y = NONE;
      if (i == 0) begin tbl[i].x = 10'd0; tbl[i].y = 10'd0; end
      tbl[i].exp = (tbl[i].x == NONE || tbl[i].y == NONE) ? 16'h0000
                   : 16'(bank[int'(tbl[i].y[0])][int'(tbl[i].x)]);
    end
    for (int i = 0; i < 16; i++) begin
      pix_x = tbl[i].x; pix_y = tbl[i].y;
      tick();
      check($sformatf("table_pix_%0d", i), pix_data, tbl[i].exp);
    end
    pix_x = NONE; pix_y = NONE;
  endtask

  task automatic line_end_pulse(input int y);
    pix_x = 10'(HV - 1); pix_y = 10'(y);
    tick();
    pix_x = NONE; pix_y = NONE;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic any_req;
    rst_n = 1'b0; pix_x = NONE; pix_y = NONE;
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (3) tick();
    check("rst_rd_req", rd_req, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_underrun", underrun, 0);
    check("rst_cnt", underrun_cnt, 0);
    check("rst_pix_data", pix_data, 0);

    // Boot fetch of line 0, ack after 3 cycles, words 0..639.
    rst_n = 1'b1;
    serve(0, 0, 3, HV, -1, -1);

    // Sweep line 0; the final column is also the line_end that fetches line 1.
    for (int x = 0; x < HV; x++) begin
      pix_x = 10'(x); pix_y = 10'd0;
      tick();
      check("sweep_pix", pix_data, x);
    end
    pix_x = NONE; pix_y = NONE;
    tick();
    check("sweep_none", pix_data, 0);
    serve(1, $urandom_range(0, 16'hFFFF), 1, HV, -1, -1);
    run_table();

    line_end_pulse(5);
    serve(6, $urandom_range(0, 16'hFFFF), 2, HV, -1, -1);
    check("line6_addr_const", line_addr(6), 20'h00F00);
    run_table();
    line_end_pulse(VV - 1);
    serve(0, $urandom_range(0, 16'hFFFF), 0, HV, -1, -1);

    // Stall across line_end at y=10: one underrun, line 11 never fetched.
    line_end_pulse(9);
    check("stall_req", rd_req, 1);
    pix_x = 10'(HV - 1); pix_y = 10'd10;
    tick();
    exp_cnt = sat_inc(exp_cnt, 1);
    check("stall_underrun", underrun, 1);
    check("stall_cnt", underrun_cnt, exp_cnt);
    pix_x = NONE; pix_y = NONE;
    tick();
    check("stall_underrun_clear", underrun, 0);
    check("stall_addr_kept", rd_addr, line_addr(10));
    serve(10, $urandom_range(0, 16'hFFFF), 4, HV, -1, -1);
    any_req = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); any_req |= rd_req; end
    check("no_fetch_line11", any_req, 0);

    // 300 forced underruns while the request is held.
    line_end_pulse(19);
    pix_x = 10'(HV - 1);
    for (int i = 0; i < 300; i++) begin
      pix_y = 10'($urandom_range(0, VV - 1));
      tick();
      exp_cnt = sat_inc(exp_cnt, 1);
    end
    pix_x = NONE; pix_y = NONE;
    check("sat_underrun", underrun, 1);
    tick();
    check("sat_cnt", underrun_cnt, exp_cnt);
    check("sat_addr_kept", rd_addr, line_addr(20));
    serve(20, $urandom_range(0, 16'hFFFF), 2, HV, 200, -1);

    // line_end on the final word chains straight into the next fetch.
    line_end_pulse(29);
    serve(30, $urandom_range(0, 16'hFFFF), 1, HV, -1, 30);
    check("chain_req", rd_req, 1);
    check("chain_addr", rd_addr, line_addr(31));
    serve(31, $urandom_range(0, 16'hFFFF), 1, HV, -1, -1);
    run_table();

    // Reset after word 200 aborts the burst.
    line_end_pulse(40);
    serve(41, $urandom_range(0, 16'hFFFF), 1, 201, -1, -1);
    rst_n = 1'b0; rd_valid = 1'b1; rd_data = 16'hDEAD;
    pix_x = 10'd3; pix_y = 10'd0;
    tick();
    exp_cnt = 0;
    check("midrst_req", rd_req, 0);
    check("midrst_busy", fetch_busy, 0);
    check("midrst_addr", rd_addr, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_cnt", underrun_cnt, 0);
    check("midrst_pix", pix_data, 0);
    tick();
    rst_n = 1'b1; pix_x = NONE; pix_y = NONE;
    tick();
    rd_valid = 1'b0;
    serve(0, $urandom_range(0, 16'hFFFF), 2, HV, -1, -1);
    for (int x = 0; x < 4; x++) begin
      pix_x = 10'(x); pix_y = 10'd0;
      tick();
      check("post_rst_line0", pix_data, bank[0][x]);
    end
    pix_x = NONE; pix_y = NONE;
    run_table();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
